router_dest_reader: RTL
=======================

// Module: router_dest_reader
// PURPOSE
//  Destination-side consumer for one router output port: the far end of the
//  vld_out/read_enb/data_out handshake produced by the router sync + FIFO logic.
//  Detects vld_out, asserts read_enb after a programmable delay, and captures
//  header, payload and parity bytes. Checks the parity byte and the address
//  field, then reports per-packet status. Used as bench agent and on-chip sink.
// PARAMETERS
//  DATA_WIDTH  8      byte width of data_out
//  PORT_ID     2'd0   expected header addr[1:0] for this port
//  READ_DELAY  2      cycles from vld_out sampled high to first read_enb (0..28)
//  CNT_WIDTH   8      width of good-packet counter
// PORTS
//  clock        in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high
//  vld_out      in   1   FIFO non-empty (router side)
//  data_out     in   8   FIFO read data, valid the cycle after read_enb
//  soft_reset   in   1   router timeout flush for this port; aborts packet
//  stall        in   1   consumer back-pressure; holds read_enb low
//  read_enb     out  1   FIFO read strobe
//  busy         out  1   high from HDR issue until DONE/abort
//  pkt_done     out  1   1-cycle pulse, status outputs valid this cycle
//  pkt_len      out  6   payload length from header[7:2]
//  parity_err   out  1   received parity != XOR(header, payload)
//  addr_err     out  1   header[1:0] != PORT_ID
//  pkt_drop     out  1   1-cycle pulse when soft_reset aborts a packet
//  good_count   out  CNT_WIDTH  packets done with no error; saturates at max
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters and parity accumulator 0.
//  - Packet format: header {len[5:0],addr[1:0]}, len payload bytes, parity byte;
//    len=0 is legal (header + parity only).
//  - Read issue: read_enb = (state in HDR/PAY/PAR) & vld_out & ~stall &
//    (issued < len+2). Never asserted when vld_out=0.
//  - Capture: registered rd_q = read_enb; a byte is captured on each edge where
//    rd_q=1. A 1-cycle issue-to-capture latency is fixed.
//  - FSM: IDLE -(vld_out)-> WAIT; WAIT counts READ_DELAY cycles, then HDR.
//    HDR: issue 1 read; on capture latch len/addr, init parity = header -> PAY.
//    If len=0, go directly to PAR.
//    PAY: XOR each captured byte; after len captures -> PAR.
//    PAR: compare captured byte to accumulator -> DONE.
//    DONE: drive pkt_done=1 for one cycle with pkt_len/parity_err/addr_err.
//    Increment good_count if neither error is set. Then -> IDLE.
//  - READ_DELAY=0: WAIT lasts 0 cycles, so read_enb rises the cycle after
//    vld_out is seen.
//  - HDR issue gating: header len is unknown until capture, so HDR issues
//    exactly one read and waits for its capture before issuing payload reads.
//  - Gaps: vld_out low or stall high mid-packet pauses issue. No timeout is
//    applied here; the router's soft_reset governs timeouts.
//  - soft_reset, any state != IDLE: state -> IDLE next edge, read_enb 0 that
//    same cycle (combinational gate), pkt_drop pulse, no pkt_done.
//    In IDLE, soft_reset is ignored.
//  - Simultaneous soft_reset and final parity capture: abort wins.
//  - Async reset mid-packet: immediate return to reset values, no pulses.
//  - pkt_len/parity_err/addr_err hold their values until the next pkt_done.
//  - busy = state in {HDR,PAY,PAR,DONE}.
// STRUCTURE
//  - Shared package router_pkg: state encoding localparams
//    (IDLE,WAIT,HDR,PAY,PAR,DONE), header field slices (LEN_MSB=7, LEN_LSB=2,
//    ADDR_MSB=1), MAX_LEN=63.
//  - Single module; the byte counter and parity accumulator stay inline.
//  - No sub-module is needed.
// TESTING
//  1. Reset mid-PAY (len=5, 2 bytes read): all outputs 0 next cycle.
//     A following clean packet must complete normally.
//  2. Header 8'h0C (len=3, addr=0), payload 11,22,33, parity 0C^11^22^33=0C:
//     expect read_enb high for 5 reads, pkt_done, pkt_len=3, no errors,
//     good_count=1.
//  3. Same packet with parity byte 8'hFF: parity_err=1, good_count unchanged.
//     Header 8'h0D with PORT_ID=0: addr_err=1.
//  4. vld_out drops for 4 cycles after byte 2, and stall held for 3 cycles:
//     read_enb low during both; total reads still len+2; parity correct.
//  5. soft_reset asserted during PAY: read_enb 0 that cycle, pkt_drop pulse,
//     no pkt_done, FSM back to IDLE. len=0 packet {00,00}: pkt_done after
//     2 reads.
//  6. READ_DELAY=0 and READ_DELAY=5: first read_enb 1 / 6 cycles after vld_out
//     is sampled.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router destination-side reader: FSM encoding
// and header field positions.
package router_pkg;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int MAX_LEN  = 63;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_HDR  = 3'd2,
    ST_PAY  = 3'd3,
    ST_PAR  = 3'd4,
    ST_DONE = 3'd5
  } rdr_state_e;

endpackage

// File: rtl/router_dest_reader.sv
// Destination-side consumer for one router output port: pulls header, payload
// and parity bytes over vld_out/read_enb/data_out and reports packet status.
//
// state | meaning
// IDLE  | no packet, waiting for vld_out
// WAIT  | programmable delay before the first read
// HDR   | one header read issued, waiting for its capture
// PAY   | payload reads/captures, parity accumulation
// PAR   | waiting for the parity byte capture
// DONE  | one-cycle status report
module router_dest_reader
  import router_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter logic [1:0] PORT_ID    = 2'd0,
  parameter int         READ_DELAY = 2,
  parameter int         CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vld_out,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  soft_reset,
  input  logic                  stall,
  output logic                  read_enb,
  output logic                  busy,
  output logic                  pkt_done,
  output logic [5:0]            pkt_len,
  output logic                  parity_err,
  output logic                  addr_err,
  output logic                  pkt_drop,
  output logic [CNT_WIDTH-1:0]  good_count
);

  localparam logic [4:0] DLY_INIT = (READ_DELAY > 0) ? 5'(READ_DELAY - 1) : 5'd0;

  rdr_state_e            state_q, state_d;
  logic [4:0]            dly_q, dly_d;
  logic [6:0]            issued_q, issued_d;
  logic [5:0]            pay_cnt_q, pay_cnt_d;
  logic                  rd_q;
  logic [5:0]            len_q, len_d;
  logic                  addr_bad_q, addr_bad_d;
  logic                  par_bad_q, par_bad_d;
  logic [DATA_WIDTH-1:0] parity_q, parity_d;
  logic [5:0]            pkt_len_q, pkt_len_d;
  logic                  parity_err_q, parity_err_d;
  logic                  addr_err_q, addr_err_d;
  logic [CNT_WIDTH-1:0]  good_q, good_d;
  logic                  drop_q, drop_d;

  logic [6:0] limit;
  logic       active;
  logic       issue_ok;
  logic       abort;
  logic       done_ok;

  assign limit    = {1'b0, len_q} + 7'd2;
  assign active   = (state_q == ST_HDR) || (state_q == ST_PAY) || (state_q == ST_PAR);
  // Header length is unknown until captured, so HDR allows exactly one read.
  assign issue_ok = (state_q == ST_HDR) ? (issued_q == 7'd0) : (issued_q < limit);
  assign read_enb = active && vld_out && !stall && !soft_reset && issue_ok;
  assign abort    = soft_reset && (state_q != ST_IDLE);
  assign done_ok  = (state_q == ST_DONE) && !soft_reset;

  assign busy       = active || (state_q == ST_DONE);
  assign pkt_done   = done_ok;
  assign pkt_len    = done_ok ? len_q : pkt_len_q;
  assign parity_err = done_ok ? par_bad_q : parity_err_q;
  assign addr_err   = done_ok ? addr_bad_q : addr_err_q;
  assign pkt_drop   = drop_q;
  assign good_count = good_q;

  always_comb begin
    state_d      = state_q;
    dly_d        = dly_q;
    issued_d     = issued_q;
    pay_cnt_d    = pay_cnt_q;
    len_d        = len_q;
    addr_bad_d   = addr_bad_q;
    par_bad_d    = par_bad_q;
    parity_d     = parity_q;
    pkt_len_d    = pkt_len_q;
    parity_err_d = parity_err_q;
    addr_err_d   = addr_err_q;
    good_d       = good_q;
    drop_d       = 1'b0;

    if (read_enb) begin
      issued_d = issued_q + 7'd1;
    end

    case (state_q)
      ST_IDLE: begin
        issued_d  = 7'd0;
        pay_cnt_d = 6'd0;
        if (vld_out) begin
          if (READ_DELAY == 0) begin
            state_d = ST_HDR;
          end else begin
            state_d = ST_WAIT;
            dly_d   = DLY_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (dly_q == 5'd0) begin
          state_d = ST_HDR;
        end else begin
          dly_d = dly_q - 5'd1;
        end
      end
      ST_HDR: begin
        if (rd_q) begin
          len_d      = data_out[LEN_MSB:LEN_LSB];
          addr_bad_d = (data_out[ADDR_MSB:0] != PORT_ID);
          parity_d   = data_out;
          state_d    = (data_out[LEN_MSB:LEN_LSB] == 6'd0) ? ST_PAR : ST_PAY;
        end
      end
      ST_PAY: begin
        if (rd_q) begin
          parity_d  = parity_q ^ data_out;
          pay_cnt_d = pay_cnt_q + 6'd1;
          if ((pay_cnt_q + 6'd1) == len_q) begin
            state_d = ST_PAR;
          end
        end
      end
      ST_PAR: begin
        if (rd_q) begin
          par_bad_d = (data_out != parity_q);
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        pkt_len_d    = len_q;
        parity_err_d = par_bad_q;
        addr_err_d   = addr_bad_q;
        if (!par_bad_q && !addr_bad_q && (good_q != {CNT_WIDTH{1'b1}})) begin
          good_d = good_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides everything, including a parity capture or DONE report.
    if (abort) begin
      state_d      = ST_IDLE;
      drop_d       = 1'b1;
      issued_d     = 7'd0;
      pay_cnt_d    = 6'd0;
      pkt_len_d    = pkt_len_q;
      parity_err_d = parity_err_q;
      addr_err_d   = addr_err_q;
      good_d       = good_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dly_q        <= 5'd0;
      issued_q     <= 7'd0;
      pay_cnt_q    <= 6'd0;
      rd_q         <= 1'b0;
      len_q        <= 6'd0;
      addr_bad_q   <= 1'b0;
      par_bad_q    <= 1'b0;
      parity_q     <= '0;
      pkt_len_q    <= 6'd0;
      parity_err_q <= 1'b0;
      addr_err_q   <= 1'b0;
      good_q       <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      issued_q     <= issued_d;
      pay_cnt_q    <= pay_cnt_d;
      rd_q         <= read_enb;
      len_q        <= len_d;
      addr_bad_q   <= addr_bad_d;
      par_bad_q    <= par_bad_d;
      parity_q     <= parity_d;
      pkt_len_q    <= pkt_len_d;
      parity_err_q <= parity_err_d;
      addr_err_q   <= addr_err_d;
      good_q       <= good_d;
      drop_q       <= drop_d;
    end
  end

endmodule
